// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the reg_file_mp register file.
// Optional feature macro: REG_FILE_BYPASS_EN (same-cycle write-to-read bypass).
package reg_file_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int DEF_RFS   = 5;
  localparam int DEPTH     = 2 ** DEF_RFS;

  // Entry count for a given address width.
  function automatic int rf_depth(input int rfs);
    return 2 ** rfs;
  endfunction

  // Low bit of port p inside a packed multi-port bus of w-bit fields.
  function automatic int slice_lo(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Clear-sweep controller: after reset or flush walks every entry once,
// strobing a zeroing write, then declares the register file ready.
module reg_file_clear_fsm
  import reg_file_pkg::*;
#(
  parameter int REG_FILE_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  output logic                     ready,
  output logic                     clr_en,
  output logic [REG_FILE_SIZE-1:0] clr_addr
);

  localparam int NDEPTH = rf_depth(REG_FILE_SIZE);
  // One extra counter bit so the terminal count is detected without wrapping.
  localparam logic [REG_FILE_SIZE:0] LAST = (REG_FILE_SIZE+1)'(NDEPTH - 1);

  rf_state_e              state_q, state_d;
  logic [REG_FILE_SIZE:0] cnt_q, cnt_d;

  // State and sweep counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep one entry per cycle; flush always restarts the sweep.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_en   = 1'b0;
    clr_addr = cnt_q[REG_FILE_SIZE-1:0];
    case (state_q)
      RF_CLEAR: begin
        clr_en = 1'b1;
        if (cnt_q == LAST) begin
          state_d = RF_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RF_READY: ;
      default: state_d = RF_CLEAR;
    endcase
    if (flush) begin
      state_d = RF_CLEAR;
      cnt_d   = '0;
    end
  end

  assign ready = (state_q == RF_READY);

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file for the hydra core: combinational reads,
// synchronous writes (highest port wins), x0 hardwired to zero, busy scoreboard.
// Optional feature macro: REG_FILE_BYPASS_EN -- reads see same-cycle write data.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int REG_FILE_SIZE = 5,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  output logic                            ready,
  input  logic [NUM_RD*REG_FILE_SIZE-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]         rd_data,
  output logic [NUM_RD-1:0]               rd_busy,
  input  logic [NUM_WR-1:0]               wr_en,
  input  logic [NUM_WR*REG_FILE_SIZE-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]         wr_data,
  input  logic                            alloc_en,
  input  logic [REG_FILE_SIZE-1:0]        alloc_addr
);

  localparam int NDEPTH = rf_depth(REG_FILE_SIZE);

  logic                                  clr_en;
  logic [REG_FILE_SIZE-1:0]              clr_addr;
  logic [NDEPTH-1:0][WIDTH-1:0]          mem_q, mem_d;
  logic [NDEPTH-1:0]                     busy_q, busy_d;
  logic [NUM_WR-1:0][REG_FILE_SIZE-1:0]  wr_a;
  logic [NUM_WR-1:0][WIDTH-1:0]          wr_d;
  logic [NUM_WR-1:0]                     wr_ok;

  reg_file_clear_fsm #(.REG_FILE_SIZE(REG_FILE_SIZE)) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // Unpack write ports; a write counts only when ready and not aimed at x0.
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wr_a[w]  = wr_addr[slice_lo(w, REG_FILE_SIZE) +: REG_FILE_SIZE];
    assign wr_d[w]  = wr_data[slice_lo(w, WIDTH) +: WIDTH];
    assign wr_ok[w] = ready && wr_en[w] && (wr_a[w] != '0);
  end

  // Storage is zeroed by the sweep, so it needs no reset of its own.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Storage update: sweep zeroing, else writes in port order so the highest port wins.
  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[clr_addr] = '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) mem_d[wr_a[w]] = wr_d[w];
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Scoreboard update: writes retire producers, then alloc marks the new producer
  // so a same-cycle alloc and write on one register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else if (ready) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) busy_d[wr_a[w]] = 1'b0;
      end
      if (alloc_en && (alloc_addr != '0)) busy_d[alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Read muxes: x0 and the whole file read as zero / not busy until ready.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [REG_FILE_SIZE-1:0] ra;
    logic [WIDTH-1:0]         rdat;
    logic                     rbsy;
    assign ra = rd_addr[slice_lo(p, REG_FILE_SIZE) +: REG_FILE_SIZE];

    always_comb begin
      rdat = '0;
      rbsy = 1'b0;
      if (ready && (ra != '0)) begin
        rdat = mem_q[ra];
        rbsy = busy_q[ra];
`ifdef REG_FILE_BYPASS_EN
        // Ascending scan leaves the highest matching write port in place.
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_ok[w] && (wr_a[w] == ra)) begin
            rdat = wr_d[w];
            rbsy = 1'b0;
          end
        end
`endif
      end
    end

    assign rd_data[slice_lo(p, WIDTH) +: WIDTH] = rdat;
    assign rd_busy[p]                           = rbsy;
  end

endmodule
